// File: rtl/ssr_peak_search_ctrl.sv
// ssr_peak_search_ctrl: windowed argmax search over a pipelined sort tree's per-beat max.
// Define SSR_PEAK_THRESH_EN to stop at the first beat whose max reaches threshold_i.
module ssr_peak_search_ctrl #(
    parameter int DATAWIDTH = 16,
    parameter int PHASES    = 64,
    parameter int TREE_LAT  = $clog2(PHASES),
    parameter int WIN_BITS  = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               start_i,
    input  logic [WIN_BITS-1:0]                window_len_i,
    input  logic [2*DATAWIDTH-1:0]             threshold_i,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic [$clog2(PHASES)-1:0]          tree_index_i,
    input  logic [2*DATAWIDTH-1:0]             tree_value_i,
    output logic                               busy_o,
    output logic                               res_valid_o,
    input  logic                               res_ready_i,
    output logic [WIN_BITS+$clog2(PHASES)-1:0] res_pos_o,
    output logic [2*DATAWIDTH-1:0]             res_value_o,
    output logic                               res_found_o
);
    localparam int IW = $clog2(PHASES);
    localparam int VW = 2 * DATAWIDTH;
    localparam int PW = WIN_BITS + IW;

    typedef enum logic [1:0] {IDLE, SEARCH, DRAIN, DONE} state_t;

    state_t              state, state_nxt;
    logic [WIN_BITS-1:0] win_len, beat_cnt;
    logic [VW-1:0]       max_val;
    logic [PW-1:0]       max_pos, cand_pos;
    logic [TREE_LAT-1:0] dl_valid, dl_rest;
    logic [WIN_BITS-1:0] dl_beat [TREE_LAT];
    logic                accept, aligned, better, hit, pending, last_beat, launch, found_q;

    assign in_ready_o = (state == SEARCH) && (beat_cnt != win_len);
    assign accept     = in_valid_i && in_ready_o;
    assign last_beat  = accept && (beat_cnt == win_len - WIN_BITS'(1));
    assign launch     = (state == IDLE) && start_i;
    assign aligned    = dl_valid[TREE_LAT-1] && ((state == SEARCH) || (state == DRAIN));
    // PHASES is a power of two, so beat*PHASES+index is a plain concatenation
    assign cand_pos   = {dl_beat[TREE_LAT-1], tree_index_i};
    assign better     = aligned && (tree_value_i > max_val);

`ifdef SSR_PEAK_THRESH_EN
    logic [VW-1:0] thresh;
    logic          found;

    assign hit     = aligned && (tree_value_i >= thresh);
    assign found_q = found;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            thresh <= '0;
            found  <= 1'b0;
        end else if (launch) begin
            thresh <= threshold_i;
            found  <= 1'b0;
        end else if (hit) begin
            found  <= 1'b1;
        end
    end
`else
    logic unused_thresh;

    assign unused_thresh = ^threshold_i;
    assign hit           = 1'b0;
    assign found_q       = (win_len != '0);
`endif

    always_comb begin
        dl_rest = dl_valid;
        dl_rest[TREE_LAT-1] = 1'b0;
        pending = |dl_rest;
        state_nxt = state;
        unique case (state)
            IDLE:    state_nxt = start_i ? SEARCH : IDLE;
            SEARCH:  state_nxt = (hit || win_len == '0) ? DONE : last_beat ? DRAIN : SEARCH;
            DRAIN:   state_nxt = (hit || !pending) ? DONE : DRAIN;
            DONE:    state_nxt = res_ready_i ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            win_len  <= '0;
            beat_cnt <= '0;
            max_val  <= '0;
            max_pos  <= '0;
            dl_valid <= '0;
        end else begin
            state <= state_nxt;
            if (launch) begin
                win_len  <= window_len_i;
                beat_cnt <= '0;
                max_val  <= '0;
                max_pos  <= '0;
                dl_valid <= '0;
            end else begin
                dl_valid <= hit ? '0 : (dl_valid << 1) | TREE_LAT'(accept);
                if (accept) beat_cnt <= beat_cnt + WIN_BITS'(1);
                if (hit || better) begin
                    max_val <= tree_value_i;
                    max_pos <= cand_pos;
                end
            end
        end
    end

    // beat numbers ride alongside the valid bits; validity alone gates their use
    always_ff @(posedge clk_i) begin
        dl_beat[0] <= beat_cnt;
        for (int i = 1; i < TREE_LAT; i++) dl_beat[i] <= dl_beat[i-1];
    end

    assign busy_o      = (state != IDLE);
    assign res_valid_o = (state == DONE);
    assign res_pos_o   = res_valid_o ? max_pos : '0;
    assign res_value_o = res_valid_o ? max_val : '0;
    assign res_found_o = res_valid_o && found_q;
endmodule
